// File: rtl/alu_bist_ctrl_pkg.sv
// Shared constants and FSM state type for the ALU BIST controller.
// Build option ALU_BIST_ABORT_EN (see alu_bist_ctrl.sv) does not change anything here.
package alu_bist_pkg;

  localparam int OPC_W = 6;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  // Corner operands applied on pattern slots 0..2 of every opcode
  localparam logic [31:0] CORNER_MAX_POS  = 32'h7FFF_FFFF;
  localparam logic [31:0] CORNER_MIN_NEG  = 32'h8000_0000;
  localparam logic [31:0] CORNER_ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    CAPTURE = 3'd2,
    NEXT    = 3'd3,
    DONE    = 3'd4
  } bist_state_e;

endpackage

// File: rtl/alu_bist_ctrl_if.sv
// BIST-to-ALU bus: the controller drives opcode/operands, the ALU returns its
// result and flags combinationally on the same cycle.
interface alu_bist_ctrl_if;
  import alu_bist_pkg::*;

  logic [OPC_W-1:0] opcode;
  logic [31:0]      opnd1;
  logic [31:0]      opnd2;
  logic [31:0]      alu_out;
  logic             zero_flag;
  logic             overflow;

  modport master (
    output opcode, opnd1, opnd2,
    input  alu_out, zero_flag, overflow
  );

  modport slave (
    input  opcode, opnd1, opnd2,
    output alu_out, zero_flag, overflow
  );

endinterface

// File: rtl/alu_bist_ctrl_misr32.sv
// Enable-gated 32-bit shift register with polynomial feedback and parallel XOR
// input; serves as the operand LFSR (zero data) and as the response MISR.
module bist_misr32 #(
  parameter logic [31:0] POLY = 32'h0000_0000,
  parameter logic [31:0] INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_en,
  input  logic [31:0] i_data,
  output logic [31:0] o_q
);

  logic [31:0] r_q;
  logic [31:0] w_fb;

  assign w_fb = r_q[31] ? POLY : 32'h0000_0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= INIT;
    end else if (i_load) begin
      r_q <= INIT;
    end else if (i_en) begin
      r_q <= {r_q[30:0], 1'b0} ^ w_fb ^ i_data;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU built-in self-test driver: sweeps opcodes x operand patterns, folds every
// ALU response into a MISR. Define ALU_BIST_ABORT_EN to add the abort input.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int          NUM_OPS     = 18,
  parameter int          PATS_PER_OP = 16,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // start: single-cycle pulse, accepted only in IDLE or DONE; ignored while busy
  input  logic                  start,
`ifdef ALU_BIST_ABORT_EN
  input  logic                  abort,
`endif
  alu_bist_ctrl_if.master       alu_if,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [31:0]           signature,
  output bist_state_e           dbg_state
);

  localparam logic [OPC_W-1:0] OP_LAST  = OPC_W'(NUM_OPS - 1);
  localparam logic [7:0]       PAT_LAST = 8'(PATS_PER_OP - 1);

  bist_state_e      r_state;
  bist_state_e      w_state_nxt;
  logic [OPC_W-1:0] r_op_cnt;
  logic [7:0]       r_pat_cnt;
  logic [OPC_W-1:0] r_opcode;
  logic [31:0]      r_opnd1;
  logic [31:0]      r_opnd2;
  logic [31:0]      w_lfsr;
  logic [31:0]      w_misr_in;
  logic             w_start_run;
  logic             w_abort;
  logic             w_last_pat;
  logic             w_last_vec;
  logic             w_random_pat;

  assign busy         = (r_state == APPLY) || (r_state == CAPTURE) || (r_state == NEXT);
  assign done         = (r_state == DONE);
  assign pass         = done && (signature == GOLDEN_SIG);
  assign dbg_state    = r_state;

  assign w_start_run  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last_pat   = (r_pat_cnt == PAT_LAST);
  assign w_last_vec   = w_last_pat && (r_op_cnt == OP_LAST);
  assign w_random_pat = (r_pat_cnt >= 8'd3);

`ifdef ALU_BIST_ABORT_EN
  assign w_abort = abort && busy;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = APPLY;
      APPLY:      w_state_nxt = CAPTURE;
      CAPTURE:    w_state_nxt = NEXT;
      NEXT:       w_state_nxt = w_last_vec ? DONE : APPLY;
      default:    w_state_nxt = IDLE;
    endcase
    if (w_abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_cnt  <= '0;
      r_pat_cnt <= '0;
    end else if (w_start_run) begin
      r_op_cnt  <= '0;
      r_pat_cnt <= '0;
    end else if (r_state == NEXT) begin
      if (w_last_pat) begin
        r_pat_cnt <= '0;
        r_op_cnt  <= r_op_cnt + 1'b1;
      end else begin
        r_pat_cnt <= r_pat_cnt + 8'd1;
      end
    end
  end

  // Operands are registered so the ALU sees stable inputs for the whole CAPTURE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_opnd1  <= '0;
      r_opnd2  <= '0;
    end else if ((r_state == APPLY) && !w_abort) begin
      r_opcode <= r_op_cnt;
      case (r_pat_cnt)
        8'd0: begin
          r_opnd1 <= 32'h0000_0000;
          r_opnd2 <= 32'h0000_0000;
        end
        8'd1: begin
          r_opnd1 <= CORNER_MAX_POS;
          r_opnd2 <= 32'h0000_0001;
        end
        8'd2: begin
          r_opnd1 <= CORNER_MIN_NEG;
          r_opnd2 <= CORNER_ALL_ONES;
        end
        default: begin
          r_opnd1 <= w_lfsr;
          r_opnd2 <= {w_lfsr[15:0], w_lfsr[31:16]};
        end
      endcase
    end
  end

  assign alu_if.opcode = r_opcode;
  assign alu_if.opnd1  = r_opnd1;
  assign alu_if.opnd2  = r_opnd2;

  bist_misr32 #(
    .POLY (LFSR_TAPS),
    .INIT (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start_run),
    .i_en   ((r_state == NEXT) && w_random_pat),
    .i_data (32'h0000_0000),
    .o_q    (w_lfsr)
  );

  assign w_misr_in = alu_if.alu_out ^ {30'b0, alu_if.overflow, alu_if.zero_flag};

  // An abort landing on CAPTURE must not fold, so the signature freezes as-is
  bist_misr32 #(
    .POLY (MISR_POLY),
    .INIT (32'h0000_0000)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start_run),
    .i_en   ((r_state == CAPTURE) && !w_abort),
    .i_data (w_misr_in),
    .o_q    (signature)
  );

endmodule
